// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared types and constants for the KGP-RISC branch-resolution controller.
package kgp_branch_pkg;

  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StEval,
    StRedirect
  } br_state_e;

  localparam logic [1:0] COND_GT    = 2'b00;
  localparam logic [1:0] COND_LT    = 2'b01;
  localparam logic [1:0] COND_EQ    = 2'b10;
  localparam logic [1:0] COND_NEVER = 2'b11;

  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Branch request channel from decode to the branch-resolution controller.
interface branch_resolve_ctrl_if #(
  parameter int unsigned PC_W = 32
) ();

  logic            br_valid;
  logic            br_ready;
  logic            br_uncond;
  logic [1:0]      br_opcond;
  logic [31:0]     br_rs;
  logic [PC_W-1:0] br_pc;
  logic [31:0]     br_offset;

  modport master (
    output br_valid, br_uncond, br_opcond, br_rs, br_pc, br_offset,
    input  br_ready
  );

  modport slave (
    input  br_valid, br_uncond, br_opcond, br_rs, br_pc, br_offset,
    output br_ready
  );

endinterface

// File: rtl/branch_resolve_ctrl_sat_counter.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module br_sat_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch-resolution controller: accepts a branch, drives the condition evaluator, owns the PC.
// Optional statistics counters are built when BR_STATS_EN is defined.
module branch_resolve_ctrl
  import kgp_branch_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 adv,
  branch_resolve_ctrl_if.slave br_if,
  output logic [1:0]           opcond,
  output logic [31:0]          cond_a,
  input  logic                 cond_y,
  output logic [PC_W-1:0]      pc,
  output logic                 flush,
  output logic                 resolved,
  output logic                 taken
`ifdef BR_STATS_EN
  ,
  output logic [31:0]          br_count,
  output logic [31:0]          taken_count
`endif
);

  br_state_e state_q, state_d;

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    bpc_q, bpc_d;
  logic signed [31:0] off_q, off_d;
  logic [31:0]        rs_q, rs_d;
  logic [1:0]         opcond_q, opcond_d;
  logic               uncond_q, uncond_d;
  logic               ready_q, ready_d;
  logic               resolved_q, resolved_d;
  logic               taken_q, taken_d;
  logic               flush_q, flush_d;
  logic [PC_W-1:0]    target;

  // Offset is signed; sign-extend (or truncate) to the PC width so the sum wraps.
  assign target = bpc_q + PC_W'(off_q);

  always_comb begin
    state_d    = state_q;
    bpc_d      = bpc_q;
    off_d      = off_q;
    rs_d       = rs_q;
    opcond_d   = opcond_q;
    uncond_d   = uncond_q;
    ready_d    = 1'b0;
    resolved_d = 1'b0;
    taken_d    = 1'b0;
    flush_d    = 1'b0;
    pc_d       = adv ? (pc_q + PC_W'(INSTR_BYTES)) : pc_q;

    case (state_q)
      StInit: begin
        state_d = StIdle;
        ready_d = 1'b1;
      end
      StIdle: begin
        if (br_if.br_valid && ready_q) begin
          bpc_d    = br_if.br_pc;
          off_d    = br_if.br_offset;
          rs_d     = br_if.br_rs;
          opcond_d = br_if.br_opcond;
          uncond_d = br_if.br_uncond;
          state_d  = StEval;
        end else begin
          ready_d = 1'b1;
        end
      end
      StEval: begin
        // Evaluator result is sampled here so the redirect outputs are registered.
        taken_d    = uncond_q | cond_y;
        flush_d    = uncond_q | cond_y;
        resolved_d = 1'b1;
        state_d    = StRedirect;
      end
      StRedirect: begin
        if (taken_q) begin
          pc_d = target;
        end
        ready_d = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StInit;
      pc_q       <= RESET_PC;
      bpc_q      <= '0;
      off_q      <= '0;
      rs_q       <= '0;
      opcond_q   <= COND_GT;
      uncond_q   <= 1'b0;
      ready_q    <= 1'b0;
      resolved_q <= 1'b0;
      taken_q    <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      bpc_q      <= bpc_d;
      off_q      <= off_d;
      rs_q       <= rs_d;
      opcond_q   <= opcond_d;
      uncond_q   <= uncond_d;
      ready_q    <= ready_d;
      resolved_q <= resolved_d;
      taken_q    <= taken_d;
      flush_q    <= flush_d;
    end
  end

  assign br_if.br_ready = ready_q;
  assign opcond         = opcond_q;
  assign cond_a         = rs_q;
  assign pc             = pc_q;
  assign flush          = flush_q;
  assign resolved       = resolved_q;
  assign taken          = taken_q;

`ifdef BR_STATS_EN
  br_sat_counter u_br_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (resolved_q),
    .count (br_count)
  );

  br_sat_counter u_taken_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (resolved_q & taken_q),
    .count (taken_count)
  );
`endif

endmodule

// File: doc/branch_resolve_ctrl.md
# branch_resolve_ctrl

Sequential branch-resolution controller for the KGP-RISC core. It sits on the other side of the condition evaluator. It accepts branch requests from decode over a valid/ready handshake and drives the condition code and test operand to the evaluator. It samples the evaluator's single-bit result, then owns the program counter: it either redirects to the branch target with a one-cycle flush pulse or continues sequential advance.

## Interface
- PC_W, 32, program-counter width
- RESET_PC, 32'h00000000, PC value loaded on reset
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- adv  in  1  fetch accepted an instruction; advance PC by INSTR_BYTES
- br_valid  in  1  branch request valid
- br_ready  out  1  controller can accept a request
- br_uncond  in  1  unconditional jump; cond_y is ignored
- br_opcond  in  2  condition code: 00 gt-zero, 01 lt-zero, 10 eq-zero, 11 never
- br_rs  in  32  signed register value under test
- br_pc  in  PC_W  PC of the branch instruction
- br_offset  in  32  signed byte offset relative to br_pc
- opcond  out  2  condition code to the evaluator
- cond_a  out  32  operand to the evaluator, compared against zero
- cond_y  in  1  evaluator result
- pc  out  PC_W  current program counter
- flush  out  1  one-cycle pulse on a taken redirect
- resolved  out  1  one-cycle pulse when a branch is resolved
- taken  out  1  valid with resolved; 1 = branch taken

## Operation
- States: INIT, IDLE, EVAL, REDIRECT.
  - INIT is the reset state.
  - INIT→IDLE unconditionally on the next clock.
- IDLE: br_ready=1.
  - On br_valid&&br_ready, capture br_uncond, br_opcond, br_rs, br_pc and br_offset.
  - Go to EVAL.
- EVAL: opcond and cond_a are driven from the captured registers and held stable for the whole cycle.
  - cond_y is sampled at the end of EVAL.
  - Go to REDIRECT.
- REDIRECT:
  - taken_i = captured br_uncond | sampled cond_y.
  - resolved=1, taken=taken_i, flush=taken_i.
  - Go to IDLE.
- br_ready=0 in INIT, EVAL and REDIRECT.
- Target = captured br_pc + captured br_offset, truncated to PC_W (wraps modulo 2^PC_W).
- PC update at each clock edge:
  - REDIRECT with taken_i: pc <= target. adv in the same cycle is ignored (redirect wins).
  - Otherwise, if adv: pc <= pc + 4, wrapping at 2^PC_W.
  - Otherwise, hold.
- br_opcond=11 with br_uncond=0: the evaluator returns 0, so the branch resolves not-taken with no flush.
- opcond/cond_a outside EVAL hold their last driven values (reset 2'b00 / 0).

## Timing
- Request accepted at cycle N.
  - EVAL at N+1.
  - REDIRECT at N+2: resolved, taken and flush asserted.
  - New pc visible at N+3.
  - br_ready high again at N+3.
- Throughput: one branch per 3 cycles. br_valid may stay high; the next accept is at N+3.
- Reset values:
  - pc=RESET_PC
  - br_ready=0
  - flush=0, resolved=0, taken=0
  - opcond=2'b00, cond_a=0
  - state INIT
- First accept is possible no earlier than the second clock after rst_n rises.
- Reset asserted mid-branch (EVAL or REDIRECT) aborts immediately and asynchronously. The pending branch is discarded and no flush is issued.
- flush and resolved are exactly one cycle wide and never asserted outside REDIRECT.

## Configuration
- BR_STATS_EN defined:
  - Adds outputs br_count (32) and taken_count (32), both reset to 0.
  - br_count increments on every resolved.
  - taken_count increments on every resolved&&taken.
  - Both saturate at 32'hFFFFFFFF.
- BR_STATS_EN undefined: the ports and logic are absent; all other behaviour is identical.

## Structure
- Shared package kgp_branch_pkg holds:
  - the state enum (INIT, IDLE, EVAL, REDIRECT)
  - opcond encodings COND_GT=2'b00, COND_LT=2'b01, COND_EQ=2'b10, COND_NEVER=2'b11
  - INSTR_BYTES=4
- One sub-module: br_sat_counter (32-bit saturating counter with increment enable). It is instantiated twice, only under BR_STATS_EN.

## Test plan
- Conditional taken:
  - Stimulus: reset, then br_pc=0x100, br_offset=0x40, br_opcond=00, cond_y=1 (evaluator fed br_rs=5).
  - Response: resolved/taken/flush at N+2; pc=0x140 at N+3.
- Conditional not-taken with adv:
  - Stimulus: br_opcond=10, br_rs=7, cond_y=0, adv held high, starting from pc=0x20.
  - Response: no flush; pc=0x2C at N+3.
- Unconditional with adv in REDIRECT:
  - Stimulus: br_uncond=1, br_opcond=11, cond_y=0, adv=1 during REDIRECT.
  - Response: taken=1, flush=1; pc=target (adv ignored).
- Wrap-around:
  - Stimulus: br_pc=0xFFFFFFF0, br_offset=0x20.
  - Response: pc=0x00000010 after the taken redirect.
- Reset mid-branch:
  - Stimulus: drop rst_n during EVAL.
  - Response: pc=RESET_PC and all pulses 0; br_ready=0 for one cycle after release, then 1.
- BR_STATS_EN:
  - Stimulus: 3 taken and 2 not-taken branches.
  - Response: br_count=5, taken_count=3. With the counter forced to 0xFFFFFFFF, it stays at 0xFFFFFFFF.
